// File: rtl/gauss_window_feeder_pkg.sv
// Shared definitions for the 3x3 Gaussian window feeder and its filter:
// window byte order, tap offsets, kernel weights and row-slot arithmetic.
package gauss_window_feeder_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned WIN_LEN = 9;

    typedef enum logic {
        ST_ACCEPT,
        ST_EMIT
    } feeder_state_t;

    typedef logic [1:0] slot_t;

    // Byte k of a window sits at row offset TAP_DR[k], column offset TAP_DC[k]
    localparam logic [1:0] TAP_DR [WIN_LEN] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    localparam logic [1:0] TAP_DC [WIN_LEN] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    localparam logic [3:0] GAUSS_W [WIN_LEN] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd4, 4'd2, 4'd1, 4'd2, 4'd1};
    localparam int unsigned GAUSS_SHIFT = 4;

    function automatic slot_t slot_add(input slot_t s, input logic [1:0] n);
        logic [2:0] sum;
        sum = {1'b0, s} + {1'b0, n};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage

// File: rtl/gauss_window_feeder_if.sv
// Pixel-in / window-byte-out handshake bundle of the Gaussian window feeder.
// The master side is the feeder; the slave side is the UART/filter environment.
interface gauss_window_feeder_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              frame_done;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, frame_done
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, frame_done
    );
endinterface

// File: rtl/gauss_row_buffer.sv
// Three image-row slots with one write port and one registered read port.
// Storage is never cleared; only the read register resets.
module gauss_row_buffer
    import gauss_window_feeder_pkg::*;
#(
    parameter  int unsigned IMG_W  = 64,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned COL_W  = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  slot_t             wr_slot,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  slot_t             rd_slot,
    input  logic [COL_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [3][IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_slot][rd_col];
        end
    end

endmodule

// File: rtl/gauss_window_feeder.sv
// Buffers raster pixels in three row slots and emits the 3x3 neighbourhood of
// every interior pixel as 9 bytes, top-left first, row-major.
module gauss_window_feeder
    import gauss_window_feeder_pkg::*;
#(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gauss_window_feeder_if.master bus
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    feeder_state_t     state, state_nxt;
    logic              armed;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    slot_t             wr_slot;
    logic [3:0]        k;
    logic [3:0]        k_nxt;
    logic [COL_W-1:0]  c0;
    slot_t             win_slot [3];
    logic              win_last;
    logic              frame_done_q;

    logic              in_ready_c;
    logic              accept;
    logic              trigger;
    logic              beat;
    logic              rd_en;
    slot_t             rd_slot;
    logic [COL_W-1:0]  rd_col;
    logic [DATA_W-1:0] rd_data;

    assign in_ready_c = armed && (state == ST_ACCEPT);
    assign accept     = in_ready_c && bus.in_valid;
    assign trigger    = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign beat       = (state == ST_EMIT) && bus.out_ready;
    assign k_nxt      = k + 4'd1;

    // Byte 0 (top slot, col-2) is read on the accepting edge itself; it never
    // aliases the pixel written on that edge, so no bypass is needed.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_slot   = slot_add(wr_slot, 2'd1);
        rd_col    = col - COL_W'(2);
        case (state)
            ST_ACCEPT: begin
                if (trigger) begin
                    state_nxt = ST_EMIT;
                    rd_en     = 1'b1;
                end
            end
            ST_EMIT: begin
                if (beat) begin
                    if (k == 4'd8) begin
                        state_nxt = ST_ACCEPT;
                    end else begin
                        rd_en   = 1'b1;
                        rd_slot = win_slot[TAP_DR[k_nxt]];
                        rd_col  = c0 + COL_W'(TAP_DC[k_nxt]);
                    end
                end
            end
            default: state_nxt = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ACCEPT;
            armed        <= 1'b0;
            col          <= '0;
            row          <= '0;
            wr_slot      <= '0;
            k            <= '0;
            c0           <= '0;
            win_slot     <= '{default: '0};
            win_last     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            armed        <= 1'b1;
            frame_done_q <= beat && (k == 4'd8) && win_last;
            if (accept) begin
                if (col == COL_W'(IMG_W - 1)) begin
                    col     <= '0;
                    wr_slot <= slot_add(wr_slot, 2'd1);
                    row     <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (trigger) begin
                k           <= '0;
                c0          <= col - COL_W'(2);
                win_slot[0] <= slot_add(wr_slot, 2'd1);
                win_slot[1] <= slot_add(wr_slot, 2'd2);
                win_slot[2] <= wr_slot;
                win_last    <= (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
            end else if (beat && (k != 4'd8)) begin
                k <= k_nxt;
            end
        end
    end

    gauss_row_buffer #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W)
    ) u_row_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_slot (wr_slot),
        .wr_col  (col),
        .wr_data (bus.in_data),
        .rd_en   (rd_en),
        .rd_slot (rd_slot),
        .rd_col  (rd_col),
        .rd_data (rd_data)
    );

    assign bus.in_ready   = in_ready_c;
    assign bus.out_data   = rd_data;
    assign bus.out_valid  = (state == ST_EMIT);
    assign bus.out_last   = (state == ST_EMIT) && (k == 4'd8);
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_gauss_window_feeder.sv
// Directed bench for gauss_window_feeder: a 4x4 instance for the hand-worked
// frames, stall and reset cases, and a 64x64 instance against an image model.
module tb_gauss_window_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gauss_window_feeder_if #(.DATA_W(8)) bus4 ();
    gauss_window_feeder_if #(.DATA_W(8)) bus64 ();

    gauss_window_feeder #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    gauss_window_feeder #(.IMG_W(64), .IMG_H(64), .DATA_W(8)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

    int total = 0;
    int bad   = 0;
    int nwin4 = 0;
    int nwin64 = 0;
    logic [7:0] img [4096];

    always @(posedge clk) if (bus4.out_valid && bus4.out_ready && bus4.out_last) nwin4++;
    always @(posedge clk) if (bus64.out_valid && bus64.out_ready && bus64.out_last) nwin64++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send4(input logic [7:0] px);
        check_eq("in_ready4", 32'(bus4.in_ready), 32'd1);
        bus4.in_data  = px;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        check_eq("fdone_idle4", 32'(bus4.frame_done), 32'd0);
    endtask

    // One 4x4 frame of base+p pixels; optional stall or reset inside the first window.
    task automatic run_frame4(input int base, input int stall_k, input int rst_k);
        int w0;
        bit first;
        int r, c;
        logic [7:0] e;
        w0 = nwin4;
        first = 1'b1;
        for (int p = 0; p < 16; p++) begin
            r = p / 4;
            c = p % 4;
            send4(8'(base + p));
            if (r >= 2 && c >= 2) begin
                for (int k = 0; k < 9; k++) begin
                    e = 8'(base + 4 * (r - 2 + k / 3) + (c - 2 + k % 3));
                    check_eq("win4", {bus4.out_valid, bus4.out_last, bus4.out_data},
                             {1'b1, (k == 8), e});
                    check_eq("busy4", 32'(bus4.in_ready), 32'd0);
                    if (first && k == stall_k) begin
                        bus4.out_ready = 1'b0;
                        bus4.in_valid  = 1'b1;
                        bus4.in_data   = 8'hEE;
                        repeat (3) begin
                            @(negedge clk);
                            check_eq("stall4", {bus4.out_valid, bus4.out_last, bus4.out_data, bus4.in_ready},
                                     {1'b1, 1'b0, e, 1'b0});
                        end
                        bus4.in_valid  = 1'b0;
                        bus4.out_ready = 1'b1;
                    end
                    if (first && k == rst_k) begin
                        #2 rst_n = 1'b0;
                        #1 check_eq("rst_abort4", {bus4.out_valid, bus4.out_last, bus4.in_ready}, 32'd0);
                        @(negedge clk);
                        rst_n = 1'b1;
                        @(negedge clk);
                        return;
                    end
                    @(negedge clk);
                end
                first = 1'b0;
                check_eq("ready_back4", 32'(bus4.in_ready), 32'd1);
                check_eq("fdone4", 32'(bus4.frame_done), 32'(p == 15));
            end else begin
                check_eq("no_win4", 32'(bus4.out_valid), 32'd0);
            end
        end
        check_eq("nwin4", 32'(nwin4 - w0), 32'd4);
    endtask

    task automatic run_frame64();
        int r, c, w0;
        logic [7:0] e;
        w0 = nwin64;
        for (int p = 0; p < 4096; p++) begin
            r = p / 64;
            c = p % 64;
            check_eq("in_ready64", 32'(bus64.in_ready), 32'd1);
            bus64.in_data  = img[p];
            bus64.in_valid = 1'b1;
            @(negedge clk);
            bus64.in_valid = 1'b0;
            if (r >= 2 && c >= 2) begin
                for (int k = 0; k < 9; k++) begin
                    e = img[(r - 2 + k / 3) * 64 + (c - 2 + k % 3)];
                    check_eq("win64", {bus64.out_valid, bus64.out_last, bus64.out_data, bus64.in_ready},
                             {1'b1, (k == 8), e, 1'b0});
                    @(negedge clk);
                end
                check_eq("fdone64", 32'(bus64.frame_done), 32'(p == 4095));
            end else begin
                check_eq("no_win64", 32'(bus64.out_valid), 32'd0);
            end
        end
        check_eq("nwin64", 32'(nwin64 - w0), 32'd3844);
    endtask

    initial begin
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.out_ready = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.in_data   = '0;
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) img[i] = 8'($urandom);

        #12;
        check_eq("rst4", {bus4.in_ready, bus4.out_valid, bus4.out_last, bus4.out_data, bus4.frame_done}, 32'd0);
        check_eq("rst64", {bus64.in_ready, bus64.out_valid, bus64.out_last, bus64.out_data, bus64.frame_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_rel4", 32'(bus4.in_ready), 32'd0);
        @(negedge clk);

        run_frame4(0, -1, -1);
        run_frame4(100, -1, -1);
        run_frame4(0, 4, -1);
        run_frame4(0, -1, 6);
        run_frame4(0, -1, -1);

        run_frame64();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gauss_window_feeder.md
Name: gauss_window_feeder

Overview:
- Producer side of the serial 3x3 Gaussian filter interface.
- Accepts raster-order pixel bytes from the UART receive path and buffers three image rows.
- For every interior pixel position, emits that position's 3x3 neighbourhood as 9 consecutive bytes, top-left first, row-major.
- The downstream filter takes one byte per strobe and produces one filtered pixel per 9 bytes.

Parameters:
- IMG_W, 64, image width in pixels (>=3)
- IMG_H, 64, image height in pixels (>=3)
- DATA_W, 8, pixel width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  DATA_W  raster pixel from the UART receiver
- in_valid  in  1  in_data is valid
- in_ready  out  1  feeder can accept in_data this cycle
- out_data  out  DATA_W  window byte to the filter data input
- out_valid  out  1  window byte strobe, drives the filter's byte-enable input
- out_ready  in  1  consumer accepts out_data; tie high for the filter, which has no backpressure
- out_last  out  1  high with the 9th byte (k=8) of each window
- frame_done  out  1  one-cycle pulse after the last window of a frame

Behaviour:
- Reset (async, rst_n=0):
  - in_ready=0, out_valid=0, out_last=0, out_data=0, frame_done=0.
  - row/col counters=0, slot counter=0, state=ACCEPT.
  - in_ready rises in the first cycle after rst_n deasserts.
  - Row buffer contents are not cleared. They are never read before being rewritten in the current frame.
- Storage: three row slots of IMG_W x DATA_W in a register array. wr_slot ∈{0,1,2} holds the row being written.
- Counters:
  - col is 0..IMG_W-1 and row is 0..IMG_H-1, each $clog2 wide.
  - On col wrap, row increments and wr_slot advances 2->0.
  - On row wrap, the frame ends and row returns to 0.
  - wr_slot is never reset at a frame boundary; slot selection is always relative to it.
- State ACCEPT: in_ready=1, out_valid=0.
  - On in_valid&in_ready, in_data is written to slot wr_slot, column col.
  - If row>=2 and col>=2, go to EMIT with k=0 and latch c0=col-2, along with the slots top=(wr_slot+1)%3, mid=(wr_slot+2)%3, bot=wr_slot.
  - Otherwise stay in ACCEPT.
  - Counters advance in either case.
- State EMIT: in_ready=0 and in_valid is ignored.
  - out_valid=1. out_data is registered, showing byte k, where byte k = slot[k/3] at column c0+(k%3).
  - The slot order is top, mid, bot.
  - The current pixel is read from the array; write-before-read is resolved by registering the write one cycle before byte 0.
  - k advances only on out_valid&out_ready. With out_ready=0, out_data, out_valid and out_last hold stable.
  - When byte k=8 is accepted, return to ACCEPT.
  - If that window was the frame's last (accepted pixel at row=IMG_H-1, col=IMG_W-1), pulse frame_done in the next cycle.
- Latency and throughput:
  - A pixel accepted at edge N gives byte 0 valid in cycle N+1.
  - With out_ready=1, byte k appears in cycle N+1+k and in_ready=1 again in cycle N+10.
  - Pixels that trigger no window are accepted back-to-back, one per cycle.
- Output count per frame: exactly (IMG_W-2)*(IMG_H-2) windows.
  - Rows 0..1 and columns 0..1 of each row produce no window.
  - No edge padding.
- Reset mid-EMIT: the current window is aborted without completing and out_valid drops immediately. The next frame starts at row 0.

Decomposition:
- Shared package:
  - PIX_W (=8).
  - WIN_LEN (=9).
  - The kernel tap ordering constant (k -> row/col offset).
  - Filter weights, so feeder and filter agree on byte order.
- Natural sub-module: gauss_row_buffer. It holds the 3-slot storage with one write port and one registered read port addressed by (slot, col).
- Counters and the FSM live in the top.

Test Plan:
- IMG_W=IMG_H=4, pixels p=4r+c, out_ready=1:
  - After pixel 10, the bytes are 0,1,2,4,5,6,8,9,10 with out_last on 10.
  - After pixel 11, the bytes are 1,2,3,5,6,7,9,10,11.
- Same frame, continued:
  - Pixels 12 and 13 produce no output.
  - Pixel 14 gives 4,5,6,8,9,10,12,13,14.
  - Pixel 15 gives 5,6,7,9,10,11,13,14,15, followed by frame_done for one cycle.
  - Total windows = 4.
- Second frame with pixels 100+p, issued immediately after the first: the first window is 100,101,102,104,105,106,108,109,110, which checks the relative slot rotation.
- Backpressure: out_ready=0 for 3 cycles at k=4.
  - out_data holds 5 and out_valid holds 1.
  - in_valid pulses during EMIT are not accepted.
  - The sequence then completes unchanged.
- Reset at k=6 of the first window: out_valid=0 asynchronously. After release, 16 fresh pixels reproduce the first-frame sequence exactly.
- IMG_W=IMG_H=64, random pixels, out_ready=1: a reference model compares all 3844 windows. in_ready is 0 for exactly 9 cycles per window-triggering pixel.
